// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter sharing one combinational FP32 divider between two requesters.
// Operands are held on div_a/div_b for DIV_CYCLES cycles (multicycle path) before the
// result and flags are captured and returned with the requester id and tag.
module fp_div_arbiter #(
    parameter int unsigned DIV_CYCLES = 4,
    parameter int unsigned TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      div_a,
    output logic [31:0]      div_b,
    input  logic [31:0]      div_result,
    input  logic             div_overflow,
    input  logic             div_underflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_result,
    output logic             rsp_ovf,
    output logic             rsp_unf,
    output logic             rsp_dz,
    output logic             busy
);

    // A one-cycle hold still needs a 1-bit counter that is simply loaded with zero.
    localparam int unsigned CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic [31:0]      div_a_q, div_a_d;
    logic [31:0]      div_b_q, div_b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             rsp_unf_q, rsp_unf_d;
    logic             rsp_dz_q, rsp_dz_d;
    logic             busy_q, busy_d;

    logic             grant_valid_c;
    logic             grant_id_c;
    logic             a_nan_c;
    logic             b_nan_c;
    logic             dz_c;

    // Round-robin pick: a lone requester wins, a tie goes to the one not granted last.
    always_comb begin
        grant_valid_c = req0_valid | req1_valid;
        grant_id_c    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    end

    assign req0_ready = (state_q == ST_IDLE) && grant_valid_c && !grant_id_c;
    assign req1_ready = (state_q == ST_IDLE) && grant_valid_c &&  grant_id_c;

    // Divide-by-zero from the held operands: zero divisor (either sign), no NaN involved.
    always_comb begin
        a_nan_c = (&div_a_q[30:23]) && (|div_a_q[22:0]);
        b_nan_c = (&div_b_q[30:23]) && (|div_b_q[22:0]);
        dz_c    = (div_b_q[30:0] == 31'd0) && !a_nan_c && !b_nan_c;
    end

    // Next-state and registered-output logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        tag_d        = tag_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_result_d = rsp_result_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_unf_d    = rsp_unf_q;
        rsp_dz_d     = rsp_dz_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid_c) begin
                    div_a_d      = grant_id_c ? req1_a   : req0_a;
                    div_b_d      = grant_id_c ? req1_b   : req0_b;
                    tag_d        = grant_id_c ? req1_tag : req0_tag;
                    id_d         = grant_id_c;
                    last_grant_d = grant_id_c;
                    cnt_d        = CNT_W'(DIV_CYCLES - 1);
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = id_q;
                    rsp_tag_d    = tag_q;
                    rsp_result_d = div_result;
                    rsp_ovf_d    = div_overflow;
                    rsp_unf_d    = div_underflow;
                    rsp_dz_d     = dz_c;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            div_a_q      <= '0;
            div_b_q      <= '0;
            tag_q        <= '0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_result_q <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_unf_q    <= 1'b0;
            rsp_dz_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            tag_q        <= tag_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_result_q <= rsp_result_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_unf_q    <= rsp_unf_d;
            rsp_dz_q     <= rsp_dz_d;
            busy_q       <= busy_d;
        end
    end

    assign div_a      = div_a_q;
    assign div_b      = div_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_result = rsp_result_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign rsp_unf    = rsp_unf_q;
    assign rsp_dz     = rsp_dz_q;
    assign busy       = busy_q;

endmodule
